// File: rtl/blit_pkg.sv
// Shared types and constants for the blit pixel writer.
package blit_pkg;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int ADDR_W         = 26;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        colour;
  } wr_entry_t;

  function automatic logic [3:0] wstrb_from_off(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction
endpackage

// File: rtl/blit_wr_fifo.sv
// Synchronous write queue with occupancy count and show-ahead head.
module blit_wr_fifo
  import blit_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  wr_entry_t     din,
  input  logic          pop,
  output wr_entry_t     head,
  output logic [CW-1:0] count
);
  wr_entry_t      mem [DEPTH];
  logic [PW-1:0]  wp, rp;
  logic           do_push, do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rp];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/blit_pixel_writer.sv
// Clips pixels, forms byte addresses and issues byte-strobed 32-bit bus writes.
module blit_pixel_writer
  import blit_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [15:0]       x,
  input  logic [15:0]       y,
  input  logic              write_enable,
  input  logic [7:0]        colour,
  input  logic [15:0]       clip_x1,
  input  logic [15:0]       clip_y1,
  input  logic [15:0]       clip_x2,
  input  logic [15:0]       clip_y2,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       stride,
  output logic              stall,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              v1, v2;
  logic [ADDR_W-1:0] prod;
  logic [15:0]       x1;
  logic [7:0]        col1;
  wr_entry_t         ent2, head;
  logic [CW-1:0]     count;

  // Only the low ADDR_W bits of y*stride can reach the wrapped address.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v1   <= 1'b0;
      prod <= '0;
      x1   <= '0;
      col1 <= '0;
      v2   <= 1'b0;
      ent2 <= '0;
    end else begin
      v1   <= write_enable &&
              ($signed(x) >= $signed(clip_x1)) && ($signed(x) < $signed(clip_x2)) &&
              ($signed(y) >= $signed(clip_y1)) && ($signed(y) < $signed(clip_y2));
      prod <= ADDR_W'({16'b0, y} * {16'b0, stride});
      x1   <= x;
      col1 <= colour;
      v2   <= v1;
      ent2.addr   <= base_addr + prod + ADDR_W'(x1);
      ent2.colour <= col1;
    end
  end

  blit_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (v2),
    .din    (ent2),
    .pop    (mem_ack),
    .head   (head),
    .count  (count)
  );

  // Leaves room for the two pixels already in S1/S2 when upstream sees stall.
  assign stall     = (int'(count) + int'(v1) + int'(v2)) >= FIFO_DEPTH - 1;
  assign busy      = v1 | v2 | (count != '0);
  assign mem_req   = (count != '0);
  assign mem_addr  = mem_req ? {head.addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? {4{head.colour}} : '0;
  assign mem_wstrb = mem_req ? wstrb_from_off(head.addr[1:0]) : '0;
endmodule

// File: tb/tb_blit_pixel_writer.sv
// Randomised bench for blit_pixel_writer against a queue-based reference model.
module tb_blit_pixel_writer;
  import blit_pkg::*;
  localparam int D = FIFO_DEPTH_DEF;

  logic              clock, resetn;
  logic [15:0]       x, y, clip_x1, clip_y1, clip_x2, clip_y2, stride;
  logic              write_enable, mem_ack;
  logic [7:0]        colour;
  logic [ADDR_W-1:0] base_addr;
  logic              stall, busy, mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;

  blit_pixel_writer #(.FIFO_DEPTH(D)) dut (
    .clock(clock), .resetn(resetn), .x(x), .y(y), .write_enable(write_enable),
    .colour(colour), .clip_x1(clip_x1), .clip_y1(clip_y1), .clip_x2(clip_x2),
    .clip_y2(clip_y2), .base_addr(base_addr), .stride(stride), .stall(stall),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted in-clip pixel lives in q from the edge that
  // samples it until the bus takes it; it becomes visible on the bus 3 cycles on.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        col;
    int                land;
  } exp_t;
  exp_t q[$];
  int   cyc;

  function automatic bit in_clip(input logic [15:0] px, input logic [15:0] py);
    return $signed(px) >= $signed(clip_x1) && $signed(px) < $signed(clip_x2) &&
           $signed(py) >= $signed(clip_y1) && $signed(py) < $signed(clip_y2);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [15:0] px, input logic [15:0] py);
    longint t;
    t = longint'(base_addr) + longint'(py) * longint'(stride) + longint'(px);
    return t[ADDR_W-1:0];
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      cyc <= 0;
    end else begin
      if (mem_ack && q.size() > 0 && q[0].land <= cyc) void'(q.pop_front());
      if (write_enable && in_clip(x, y)) q.push_back('{addr_of(x, y), colour, cyc + 3});
      cyc <= cyc + 1;
    end
  end

  // Observed bus writes, for the directed literal checks.
  logic [ADDR_W-1:0] obs_addr[$];
  logic [3:0]        obs_strb[$];
  logic [31:0]       obs_data[$];
  int                obs_cyc[$];

  always @(negedge clock) begin
    if (resetn) begin
      bit                exp_req;
      logic [ADDR_W-1:0] ea;
      exp_req = q.size() > 0 && q[0].land <= cyc;
      chk("mem_req", mem_req, exp_req);
      chk("stall", stall, q.size() >= D - 1);
      chk("busy", busy, q.size() != 0);
      chk("push_when_full", dut.v2 && (dut.count == D), 0);
      if (exp_req) begin
        ea = q[0].addr;
        chk("mem_addr", mem_addr, {ea[ADDR_W-1:2], 2'b00});
        chk("mem_wstrb", mem_wstrb, 4'b0001 << ea[1:0]);
        chk("mem_wdata", mem_wdata, {4{q[0].col}});
      end else begin
        chk("idle_bus", {mem_addr, mem_wdata, mem_wstrb}, 0);
      end
      if (mem_req && mem_ack) begin
        obs_addr.push_back(mem_addr);
        obs_strb.push_back(mem_wstrb);
        obs_data.push_back(mem_wdata);
        obs_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit we, input int px, input int py, input logic [7:0] col);
    write_enable = we;
    x = px[15:0];
    y = py[15:0];
    colour = col;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) step();
    chk("idle_timeout", busy, 0);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack = ($urandom_range(0, 9) < 7);
      if (!stall && $urandom_range(0, 3) != 0)
        drive(1, int'($urandom_range(0, 700)) - 30, int'($urandom_range(0, 520)) - 20,
              8'($urandom));
      else
        write_enable = 1'b0;
      step();
    end
    write_enable = 1'b0;
    mem_ack = 1'b1;
    wait_idle();
  endtask

  initial begin
    int n0, sent, landed;
    resetn = 1'b0;
    drive(0, 0, 0, 8'h00);
    mem_ack = 1'b1;
    clip_x1 = 16'd0; clip_y1 = 16'd0; clip_x2 = 16'd640; clip_y2 = 16'd480;
    base_addr = 26'h100000;
    stride = 16'd640;
    #1;
    chk("reset_outputs", {stall, busy, mem_req, mem_addr, mem_wdata, mem_wstrb}, 0);
    step(); step();
    resetn = 1'b1;
    step();

    // Single pixel latency and address
    drive(1, 3, 2, 8'h5A);
    step();
    write_enable = 1'b0;
    step();
    chk("t1_no_req_early", mem_req, 0);
    step();
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 26'h100500);
    chk("t1_wstrb", mem_wstrb, 4'b1000);
    chk("t1_wdata", mem_wdata, 32'h5A5A5A5A);
    wait_idle();

    // Clip boundaries
    n0 = obs_addr.size();
    drive(1, 639, 0, 8'h11); step();
    drive(1, 640, 0, 8'h22); step();
    drive(1, -1, 5, 8'h33);  step();
    drive(1, 0, 479, 8'h44); step();
    drive(1, 0, 480, 8'h55); step();
    write_enable = 1'b0;
    wait_idle();
    chk("t2_count", obs_addr.size() - n0, 2);
    if (obs_addr.size() - n0 == 2) begin
      chk("t2_addr0", obs_addr[n0], 26'h10027C);
      chk("t2_strb0", obs_strb[n0], 4'b1000);
      chk("t2_addr1", obs_addr[n0+1], 26'h14AD80);
      chk("t2_strb1", obs_strb[n0+1], 4'b0001);
    end

    // Back-pressure with the bus refusing
    n0 = obs_addr.size();
    mem_ack = 1'b0;
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      if (!stall && sent < 6) begin drive(1, sent, 7, 8'h10 + 8'(sent)); sent++; end
      else write_enable = 1'b0;
      step();
    end
    chk("t3_sent_before_stall", sent, D - 1);
    chk("t3_stall", stall, 1);
    mem_ack = 1'b1;
    for (int i = 0; i < 50 && sent < 6; i++) begin
      if (!stall) begin drive(1, sent, 7, 8'h10 + 8'(sent)); sent++; end
      else write_enable = 1'b0;
      step();
    end
    write_enable = 1'b0;
    chk("t3_sent_all", sent, 6);
    wait_idle();
    chk("t3_count", obs_addr.size() - n0, 6);
    for (int i = 0; i < 6 && n0 + i < obs_data.size(); i++)
      chk("t3_order", obs_data[n0+i], {4{8'h10 + 8'(i)}});

    // Streaming with an always-ready bus
    n0 = obs_addr.size();
    for (int i = 0; i < 20; i++) begin
      drive(1, i, 1, 8'(i + 1));
      step();
      if (i == 10) chk("t4_inflight", q.size(), 3);
    end
    write_enable = 1'b0;
    wait_idle();
    chk("t4_count", obs_addr.size() - n0, 20);
    if (obs_addr.size() - n0 == 20) chk("t4_throughput", obs_cyc[n0+19] - obs_cyc[n0], 19);

    // Address wrap
    base_addr = 26'h3FFFFFF;
    drive(1, 1, 0, 8'h77);
    step();
    write_enable = 1'b0;
    step(); step();
    chk("t5_req", mem_req, 1);
    chk("t5_addr", mem_addr, 0);
    chk("t5_wstrb", mem_wstrb, 4'b0001);
    wait_idle();
    base_addr = 26'h100000;

    // Reset with writes queued
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1, 10 + i, 3, 8'hC0 + 8'(i)); step(); end
    write_enable = 1'b0;
    step(); step();
    landed = 0;
    foreach (q[i]) if (q[i].land <= cyc) landed++;
    chk("t6_landed", landed, 3);
    chk("t6_req_before", mem_req, 1);
    resetn = 1'b0;
    #1;
    chk("t6_reset_req", mem_req, 0);
    chk("t6_reset_busy", busy, 0);
    chk("t6_reset_stall", stall, 0);
    step(); step();
    resetn = 1'b1;
    mem_ack = 1'b1;
    n0 = obs_addr.size();
    repeat (10) step();
    chk("t6_no_stale", obs_addr.size() - n0, 0);

    // Random traffic, two configurations
    rand_phase(400);
    clip_x1 = 16'hFFF6; clip_y1 = 16'd20; clip_x2 = 16'd300; clip_y2 = 16'd200;
    base_addr = 26'h3FF0000 + 26'($urandom_range(0, 255));
    stride = 16'd1027;
    rand_phase(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
